xnor_gate: RTL and testbench
============================

Name: xnor_gate

Overview:
- Registered bitwise XNOR unit for the integer ALU datapath: result[i] = ~(A[i] ^ B[i]).
- Sits beside the other logic-op units (and/or/xor) and feeds the ALU result mux.
- One-cycle latency, valid-qualified, with equality and zero status flags for the ALU flag logic.

Parameters:
- WIDTH, 4, operand and result width in bits (legal range 1..64).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  A/B are valid this cycle.
- A  input  WIDTH  operand A.
- B  input  WIDTH  operand B.
- result  output  WIDTH  registered bitwise XNOR of the captured A and B.
- out_valid  output  1  result and flags are valid.
- eq_flag  output  1  1 when all result bits are 1, i.e. the captured A equals B.
- zero_flag  output  1  1 when all result bits are 0, i.e. the captured A equals ~B.

Behaviour:
- Reset: when rst=1 at a clk edge, result=0, out_valid=0, eq_flag=0, zero_flag=0.
  - The reset value of result is 0, not the XNOR of zero operands.
  - rst takes priority over in_valid on the same edge.
- Capture: on a clk edge with rst=0 and in_valid=1:
  - result <= ~(A ^ B), all WIDTH bits evaluated independently.
  - eq_flag <= &(~(A ^ B)).
  - zero_flag <= ~|(~(A ^ B)).
  - out_valid <= 1.
- Latency: exactly 1 cycle from in_valid to out_valid; back-to-back operation gives one result per cycle.
- Hold: on a clk edge with rst=0 and in_valid=0:
  - result, eq_flag and zero_flag keep their previous values.
  - out_valid <= 0.
- No backpressure. The consumer must sample while out_valid=1.
- X/Z handling: no checks are performed; X on an input propagates to the corresponding result bit.
- Reset mid-stream: a capture pending on the reset edge is discarded; out_valid stays 0 until the first post-reset in_valid.
- No arithmetic widening or carry: output width equals input width.

Optional Feature:
- Macro: XNOR_GATE_MASK_EN.
- Defined:
  - Adds input port mask (WIDTH bits).
  - On capture, result <= ~(A ^ B) & mask; masked-off bits read 0.
  - eq_flag is 1 when every bit with mask=1 has A==B; it is 1 when mask=0.
  - zero_flag is computed on the masked result.
- Undefined: no mask port; behaviour is exactly as in Behaviour.

Decomposition:
- Shared package alu_pkg holds:
  - the default operand width constant (4);
  - an opcode enum entry for XNOR, used by the ALU mux (not by this block).
- One natural sub-module: xnor_flag_calc, a combinational block that takes a WIDTH-bit vector and produces the all-ones and all-zeros flags. The same block is reusable by the xor/and units.

Test Plan:
- Basic capture: reset, then A=1100, B=1001, in_valid=1 -> next cycle result=1010, out_valid=1, eq_flag=0, zero_flag=0.
- Second vector: A=0000, B=0011, in_valid=1 -> result=1100, eq_flag=0, zero_flag=0.
- Equality: A=B=0110 -> result=1111, eq_flag=1. Complement: A=1010, B=0101 -> result=0000, zero_flag=1.
- Hold: in_valid=0 for 10 cycles after a capture -> result unchanged, out_valid=0.
- Reset mid-stream: in_valid=1 and rst=1 on the same edge with A=1111, B=0000 -> result=0000, out_valid=0, both flags 0.
- Mask (XNOR_GATE_MASK_EN only): A=1100, B=1001, mask=0011 -> result=0010, eq_flag=0.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU definitions: default operand width and the result-mux opcode set.
// The XNOR opcode is consumed by the ALU mux; the logic-op units only use the width.
package alu_pkg;

    localparam int ALU_WIDTH_DEFAULT = 4;
    localparam int ALU_WIDTH_MAX     = 64;

    typedef enum logic [2:0] {
        ALU_OP_AND  = 3'd0,
        ALU_OP_OR   = 3'd1,
        ALU_OP_XOR  = 3'd2,
        ALU_OP_XNOR = 3'd3
    } alu_op_e;

    function automatic logic alu_op_is_logic(input alu_op_e op);
        return (op == ALU_OP_AND) || (op == ALU_OP_OR) ||
               (op == ALU_OP_XOR) || (op == ALU_OP_XNOR);
    endfunction

endpackage

// File: rtl/xnor_flag_calc.sv
// Combinational all-ones / all-zeros reduction of a WIDTH-bit vector.
// Shared by the logic-op units to build their ALU status flags.
module xnor_flag_calc
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic [WIDTH-1:0] vec_i,
    output logic             all_ones_o,
    output logic             all_zeros_o
);

    assign all_ones_o  = &vec_i;
    assign all_zeros_o = ~|vec_i;

endmodule

// File: rtl/xnor_gate.sv
// Registered bitwise XNOR unit with valid, equality and zero flags (1-cycle latency).
// Optional macro XNOR_GATE_MASK_EN adds a per-bit result mask input.
module xnor_gate
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
`ifdef XNOR_GATE_MASK_EN
    input  logic [WIDTH-1:0] mask,
`endif
    output logic [WIDTH-1:0] result,
    output logic             out_valid,
    output logic             eq_flag,
    output logic             zero_flag
);

    logic [WIDTH-1:0] xnor_raw;
    logic [WIDTH-1:0] result_c;
    logic             eq_c;
    logic             zero_c;

    logic [WIDTH-1:0] result_q, result_d;
    logic             valid_q, valid_d;
    logic             eq_q, eq_d;
    logic             zero_q, zero_d;

    assign xnor_raw = ~(A ^ B);

`ifdef XNOR_GATE_MASK_EN
    logic [WIDTH-1:0] eq_vec;
    logic             eq_vec_zero_unused;
    logic             res_ones_unused;

    // Masked-off bits are forced to 1 for equality so they never veto eq_flag.
    assign result_c = xnor_raw & mask;
    assign eq_vec   = xnor_raw | ~mask;

    xnor_flag_calc #(.WIDTH(WIDTH)) u_eq_calc (
        .vec_i       (eq_vec),
        .all_ones_o  (eq_c),
        .all_zeros_o (eq_vec_zero_unused)
    );

    xnor_flag_calc #(.WIDTH(WIDTH)) u_zero_calc (
        .vec_i       (result_c),
        .all_ones_o  (res_ones_unused),
        .all_zeros_o (zero_c)
    );
`else
    assign result_c = xnor_raw;

    xnor_flag_calc #(.WIDTH(WIDTH)) u_flag_calc (
        .vec_i       (result_c),
        .all_ones_o  (eq_c),
        .all_zeros_o (zero_c)
    );
`endif

    always_comb begin
        result_d = result_q;
        eq_d     = eq_q;
        zero_d   = zero_q;
        valid_d  = 1'b0;
        if (in_valid) begin
            result_d = result_c;
            eq_d     = eq_c;
            zero_d   = zero_c;
            valid_d  = 1'b1;
        end
    end

    // Reset clears result to 0 rather than the XNOR of zero operands.
    always_ff @(posedge clk) begin
        if (rst) begin
            result_q <= '0;
            valid_q  <= 1'b0;
            eq_q     <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            result_q <= result_d;
            valid_q  <= valid_d;
            eq_q     <= eq_d;
            zero_q   <= zero_d;
        end
    end

    assign result    = result_q;
    assign out_valid = valid_q;
    assign eq_flag   = eq_q;
    assign zero_flag = zero_q;

endmodule

// File: tb/tb_xnor_gate.sv
// Directed, table-driven bench for xnor_gate (WIDTH=4); covers XNOR_GATE_MASK_EN when defined.
module tb_xnor_gate;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic [W-1:0] a_in;
    logic [W-1:0] b_in;
    logic [W-1:0] mask_in;
    logic [W-1:0] result;
    logic         out_valid;
    logic         eq_flag;
    logic         zero_flag;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    xnor_gate #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .A         (a_in),
        .B         (b_in),
`ifdef XNOR_GATE_MASK_EN
        .mask      (mask_in),
`endif
        .result    (result),
        .out_valid (out_valid),
        .eq_flag   (eq_flag),
        .zero_flag (zero_flag)
    );

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic [W-1:0] exp_res;
        logic         exp_eq;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [W-1:0] r, input logic v,
                             input logic e, input logic z);
        check({tag, ".result"},    {4'b0, result},    {4'b0, r});
        check({tag, ".out_valid"}, {7'b0, out_valid}, {7'b0, v});
        check({tag, ".eq_flag"},   {7'b0, eq_flag},   {7'b0, e});
        check({tag, ".zero_flag"}, {7'b0, zero_flag}, {7'b0, z});
    endtask

    // Drive inputs just after an edge, sample just after the next edge.
    task automatic cycle(input logic r, input logic v, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        rst      = r;
        in_valid = v;
        a_in     = a;
        b_in     = b;
        @(posedge clk);
        #1;
    endtask

    initial begin
        vecs[0] = '{4'b1100, 4'b1001, 4'b1010, 1'b0, 1'b0};
        vecs[1] = '{4'b0000, 4'b0011, 4'b1100, 1'b0, 1'b0};
        vecs[2] = '{4'b0110, 4'b0110, 4'b1111, 1'b1, 1'b0};
        vecs[3] = '{4'b1010, 4'b0101, 4'b0000, 1'b0, 1'b1};
        vecs[4] = '{4'b1111, 4'b1111, 4'b1111, 1'b1, 1'b0};
        vecs[5] = '{4'b0000, 4'b0000, 4'b1111, 1'b1, 1'b0};
        vecs[6] = '{4'b0001, 4'b0000, 4'b1110, 1'b0, 1'b0};
        vecs[7] = '{4'b1000, 4'b0111, 4'b0000, 1'b0, 1'b1};

        mask_in = 4'b1111;
        rst = 1'b1; in_valid = 1'b0; a_in = '0; b_in = '0;
        @(posedge clk); #1;
        cycle(1'b1, 1'b1, 4'b0101, 4'b0101);
        check_all("reset", 4'b0000, 1'b0, 1'b0, 1'b0);

        // Back-to-back captures: one result per cycle.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, vecs[i].a, vecs[i].b);
            check_all($sformatf("vec%0d", i), vecs[i].exp_res, 1'b1,
                      vecs[i].exp_eq, vecs[i].exp_zero);
        end

        // Hold: result/flags frozen at the last capture, out_valid drops.
        cycle(1'b0, 1'b1, 4'b0110, 4'b0110);
        for (int i = 0; i < 10; i++) begin
            cycle(1'b0, 1'b0, 4'b1010, 4'b0011);
            check_all($sformatf("hold%0d", i), 4'b1111, 1'b0, 1'b1, 1'b0);
        end

        // Reset wins over a same-edge capture.
        cycle(1'b0, 1'b1, 4'b1100, 4'b1001);
        cycle(1'b1, 1'b1, 4'b1111, 4'b0000);
        check_all("rst_mid", 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b0, 4'b1111, 4'b1111);
        check_all("post_rst_idle", 4'b0000, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 1'b1, 4'b1111, 4'b0000);
        check_all("post_rst_cap", 4'b0000, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 1'b1, 4'b1001, 4'b1011);
        check_all("post_rst_cap2", 4'b1101, 1'b1, 1'b0, 1'b0);

`ifdef XNOR_GATE_MASK_EN
        mask_in = 4'b0011;
        cycle(1'b0, 1'b1, 4'b1100, 4'b1001);
        check_all("mask_basic", 4'b0010, 1'b1, 1'b0, 1'b0);
        mask_in = 4'b0110;
        cycle(1'b0, 1'b1, 4'b1011, 4'b0010);
        check_all("mask_eq", 4'b0110, 1'b1, 1'b1, 1'b0);
        mask_in = 4'b0000;
        cycle(1'b0, 1'b1, 4'b1100, 4'b0011);
        check_all("mask_none", 4'b0000, 1'b1, 1'b1, 1'b1);
        mask_in = 4'b1001;
        cycle(1'b0, 1'b1, 4'b1110, 4'b0111);
        check_all("mask_zero", 4'b0000, 1'b1, 1'b0, 1'b1);
        mask_in = 4'b1111;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
        $finish;
    end

endmodule
